ac_match_engine: RTL and testbench

- Parametrised, sequential Aho-Corasick automaton: consumes one input symbol per handshake and walks goto edges, then chases failure links one hop per cycle.
- Emits the resulting state and a pattern-match indication for every symbol.
- Sits between the symbol stream source and the match collector.
- Replaces the single-step combinational table lookup with a bounded, run-time loadable, back-pressured engine.

---
 rtl/ac_match_engine_pkg.sv | 41 ++++
 rtl/ac_match_engine_goto_cam.sv | 47 ++++
 rtl/ac_match_engine.sv | 219 +++++++++++++++++++++
 tb/tb_ac_match_engine.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ac_match_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ac_pkg
// Brief    : Shared types for the Aho-Corasick match engine: FSM states,
//            table-select encodings and goto-entry layout.
// Revision : 1.0
// ============================================================================
package ac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_RESULT = 2'd2
    } ac_state_e;

    localparam logic [1:0] c_sel_goto = 2'd0;
    localparam logic [1:0] c_sel_fail = 2'd1;
    localparam logic [1:0] c_sel_out  = 2'd2;
    localparam logic [1:0] c_sel_rsvd = 2'd3;

    // Goto entry packed MSB..LSB as {cur_state, symbol, next_state, valid}
    typedef struct packed {
        logic [7:0] cur_state;
        logic [3:0] symbol;
        logic [7:0] next_state;
        logic       valid;
    } goto_entry_t;

    localparam int c_goto_valid_lsb = 0;
    localparam int c_goto_next_lsb  = 1;

    function automatic int goto_sym_lsb(input int state_w);
        return state_w + 1;
    endfunction

    function automatic int goto_cur_lsb(input int state_w, input int sym_w);
        return state_w + sym_w + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ac_match_engine_goto_cam.sv
`default_nettype none
// ============================================================================
// Module   : ac_goto_cam
// Brief    : Parallel goto-table compare with lowest-index priority select.
// Revision : 1.0
// ============================================================================
module ac_goto_cam
    import ac_pkg::*;
#(
    parameter int NUM_EDGES = 32,
    parameter int STATE_W   = 8,
    parameter int SYM_W     = 4
) (
    input  logic [NUM_EDGES-1:0][2*STATE_W+SYM_W:0] i_entries,
    input  logic [STATE_W-1:0]                      i_probe_state,
    input  logic [SYM_W-1:0]                        i_symbol,
    output logic                                    o_hit,
    output logic [STATE_W-1:0]                      o_next_state
);

    localparam int c_sym_lsb = goto_sym_lsb(STATE_W);
    localparam int c_cur_lsb = goto_cur_lsb(STATE_W, SYM_W);

    logic [NUM_EDGES-1:0] w_match;

    generate
        for (genvar e = 0; e < NUM_EDGES; e++) begin : g_cmp
            assign w_match[e] = i_entries[e][c_goto_valid_lsb]
                && (i_entries[e][c_cur_lsb +: STATE_W] == i_probe_state)
                && (i_entries[e][c_sym_lsb +: SYM_W] == i_symbol);
        end
    endgenerate

    // Scan downward so the lowest matching index is the last to win
    always_comb begin
        o_hit        = 1'b0;
        o_next_state = '0;
        for (int e = NUM_EDGES - 1; e >= 0; e--) begin
            if (w_match[e]) begin
                o_hit        = 1'b1;
                o_next_state = i_entries[e][c_goto_next_lsb +: STATE_W];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ac_match_engine.sv
`default_nettype none
// ============================================================================
// Module   : ac_match_engine
// Brief    : Sequential Aho-Corasick matcher with run-time loadable goto,
//            failure and output tables; one failure hop per cycle.
//            Optional match counter port enabled by AC_MATCH_COUNT_EN.
// Revision : 1.0
// ============================================================================
module ac_match_engine
    import ac_pkg::*;
#(
    parameter int SYM_W      = 4,
    parameter int STATE_W    = 8,
    parameter int NUM_EDGES  = 32,
    parameter int NUM_STATES = 32,
    parameter int ID_W       = 4
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             INITIALIZE,
    input  logic                             IN_VALID,
    output logic                             IN_READY,
    input  logic [SYM_W-1:0]                 STRING,
    output logic                             OUT_VALID,
    input  logic                             OUT_READY,
    output logic [STATE_W-1:0]               NOW_STATE_OUT,
    output logic                             EN_MATCH,
    output logic [ID_W-1:0]                  MATCH_ID,
    input  logic                             CFG_WE,
    input  logic [1:0]                       CFG_SEL,
    input  logic [$clog2(NUM_EDGES)-1:0]     CFG_ADDR,
    input  logic [2*STATE_W+SYM_W:0]         CFG_DATA,
    output logic                             ERR
`ifdef AC_MATCH_COUNT_EN
    ,
    output logic [15:0]                      MATCH_CNT
`endif
);

    localparam int c_addr_w = $clog2(NUM_EDGES);
    localparam int c_sidx_w = $clog2(NUM_STATES);
    localparam int c_ent_w  = 2*STATE_W + SYM_W + 1;
    localparam int c_hop_w  = $clog2(NUM_STATES + 1);

    ac_state_e                        r_state;
    logic [NUM_EDGES-1:0][c_ent_w-1:0] r_goto;
    logic [STATE_W-1:0]               r_fail [1:NUM_STATES-1];
    logic                             r_out_match [NUM_STATES];
    logic [ID_W-1:0]                  r_out_id [NUM_STATES];

    logic [STATE_W-1:0] r_cur;
    logic [STATE_W-1:0] r_probe;
    logic [SYM_W-1:0]   r_sym;
    logic [c_hop_w-1:0] r_hop;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [STATE_W-1:0] r_now_state;
    logic               r_en_match;
    logic [ID_W-1:0]    r_match_id;
    logic               r_err;

    logic               w_hit;
    logic [STATE_W-1:0] w_hit_next;
    logic [STATE_W-1:0] w_next;
    logic [STATE_W-1:0] w_fail_rd;
    logic               w_out_match;
    logic [ID_W-1:0]    w_out_id;
    logic               w_hop_limit;
    logic               w_lookup_done;
    logic               w_overflow;
    logic               w_cfg_ok;
    logic [c_sidx_w-1:0] w_cfg_sidx;

    generate
        if (c_sidx_w <= c_addr_w) begin : g_sidx_trunc
            assign w_cfg_sidx = CFG_ADDR[c_sidx_w-1:0];
        end else begin : g_sidx_ext
            assign w_cfg_sidx = {{(c_sidx_w - c_addr_w){1'b0}}, CFG_ADDR};
        end
    endgenerate

    ac_goto_cam #(
        .NUM_EDGES (NUM_EDGES),
        .STATE_W   (STATE_W),
        .SYM_W     (SYM_W)
    ) u_cam (
        .i_entries     (r_goto),
        .i_probe_state (r_probe),
        .i_symbol      (r_sym),
        .o_hit         (w_hit),
        .o_next_state  (w_hit_next)
    );

    // Failure entry 0 is never consulted, so out-of-range probes read as 0
    always_comb begin
        w_fail_rd = '0;
        for (int i = 1; i < NUM_STATES; i++) begin
            if (r_probe == STATE_W'(i)) w_fail_rd = r_fail[i];
        end
    end

    assign w_next        = w_hit ? w_hit_next : '0;
    assign w_hop_limit   = (r_hop == c_hop_w'(NUM_STATES));
    assign w_lookup_done = w_hit || (r_probe == '0) || w_hop_limit;
    assign w_overflow    = !w_hit && (r_probe != '0) && w_hop_limit;

    always_comb begin
        w_out_match = r_out_match[0];
        w_out_id    = r_out_id[0];
        for (int i = 1; i < NUM_STATES; i++) begin
            if (w_next == STATE_W'(i)) begin
                w_out_match = r_out_match[i];
                w_out_id    = r_out_id[i];
            end
        end
    end

    assign w_cfg_ok = CFG_WE && (r_state == ST_IDLE) && !INITIALIZE;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_goto <= '0;
            for (int i = 1; i < NUM_STATES; i++) r_fail[i] <= '0;
            for (int i = 0; i < NUM_STATES; i++) begin
                r_out_match[i] <= 1'b0;
                r_out_id[i]    <= '0;
            end
        end else if (w_cfg_ok) begin
            for (int i = 0; i < NUM_EDGES; i++) begin
                if (CFG_SEL == c_sel_goto && CFG_ADDR == c_addr_w'(i)) r_goto[i] <= CFG_DATA;
            end
            for (int i = 1; i < NUM_STATES; i++) begin
                if (CFG_SEL == c_sel_fail && w_cfg_sidx == c_sidx_w'(i))
                    r_fail[i] <= CFG_DATA[STATE_W-1:0];
            end
            for (int i = 0; i < NUM_STATES; i++) begin
                if (CFG_SEL == c_sel_out && w_cfg_sidx == c_sidx_w'(i)) begin
                    r_out_match[i] <= CFG_DATA[ID_W];
                    r_out_id[i]    <= CFG_DATA[ID_W-1:0];
                end
            end
        end
    end

    // INITIALIZE wins over any handshake presented in the same cycle
    always_ff @(posedge CLK) begin
        if (RST || INITIALIZE) begin
            r_state     <= ST_IDLE;
            r_cur       <= '0;
            r_probe     <= '0;
            r_sym       <= '0;
            r_hop       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_now_state <= '0;
            r_en_match  <= 1'b0;
            r_match_id  <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (IN_VALID && r_in_ready) begin
                        r_sym      <= STRING;
                        r_probe    <= r_cur;
                        r_hop      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (w_lookup_done) begin
                        r_now_state <= w_next;
                        r_en_match  <= w_out_match;
                        r_match_id  <= w_out_match ? w_out_id : '0;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_RESULT;
                        if (w_overflow) r_err <= 1'b1;
                    end else begin
                        r_probe <= w_fail_rd;
                        r_hop   <= r_hop + c_hop_w'(1);
                    end
                end
                ST_RESULT: begin
                    if (OUT_READY) begin
                        r_cur       <= r_now_state;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef AC_MATCH_COUNT_EN
    logic [15:0] r_match_cnt;

    always_ff @(posedge CLK) begin
        if (RST || INITIALIZE) begin
            r_match_cnt <= '0;
        end else if (r_state == ST_RESULT && OUT_READY && r_en_match
                     && r_match_cnt != 16'hFFFF) begin
            r_match_cnt <= r_match_cnt + 16'd1;
        end
    end

    assign MATCH_CNT = r_match_cnt;
`endif

    assign IN_READY      = r_in_ready;
    assign OUT_VALID     = r_out_valid;
    assign NOW_STATE_OUT = r_now_state;
    assign EN_MATCH      = r_en_match;
    assign MATCH_ID      = r_match_id;
    assign ERR           = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ac_match_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_ac_match_engine
// Brief    : Directed self-checking bench for ac_match_engine using the
//            he/she/his/hers automaton.
// Revision : 1.0
// ============================================================================
module tb_ac_match_engine;

    localparam int SYM_W      = 4;
    localparam int STATE_W    = 8;
    localparam int NUM_EDGES  = 32;
    localparam int NUM_STATES = 32;
    localparam int ID_W       = 4;
    localparam int c_dw       = 2*STATE_W + SYM_W + 1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 initialize = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [SYM_W-1:0]     sym_in = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [STATE_W-1:0]   now_state;
    logic                 en_match;
    logic [ID_W-1:0]      match_id;
    logic                 cfg_we = 1'b0;
    logic [1:0]           cfg_sel = '0;
    logic [$clog2(NUM_EDGES)-1:0] cfg_addr = '0;
    logic [c_dw-1:0]      cfg_data = '0;
    logic                 err;
`ifdef AC_MATCH_COUNT_EN
    logic [15:0]          match_cnt;
`endif

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    ac_match_engine #(
        .SYM_W(SYM_W), .STATE_W(STATE_W), .NUM_EDGES(NUM_EDGES),
        .NUM_STATES(NUM_STATES), .ID_W(ID_W)
    ) dut (
        .CLK(clk), .RST(rst), .INITIALIZE(initialize),
        .IN_VALID(in_valid), .IN_READY(in_ready), .STRING(sym_in),
        .OUT_VALID(out_valid), .OUT_READY(out_ready),
        .NOW_STATE_OUT(now_state), .EN_MATCH(en_match), .MATCH_ID(match_id),
        .CFG_WE(cfg_we), .CFG_SEL(cfg_sel), .CFG_ADDR(cfg_addr), .CFG_DATA(cfg_data),
        .ERR(err)
`ifdef AC_MATCH_COUNT_EN
        , .MATCH_CNT(match_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [c_dw-1:0] edge_e(input int cur, input int sym, input int nxt);
        return {8'(cur), 4'(sym), 8'(nxt), 1'b1};
    endfunction

    task automatic cfg_write(input logic [1:0] sel, input int addr, input logic [c_dw-1:0] data);
        cfg_we   = 1'b1;
        cfg_sel  = sel;
        cfg_addr = 5'(addr);
        cfg_data = data;
        @(posedge clk); #1;
        cfg_we   = 1'b0;
    endtask

    task automatic do_init();
        initialize = 1'b1;
        @(posedge clk); #1;
        initialize = 1'b0;
    endtask

    // Waits for OUT_VALID, captures the result, then completes the handshake
    task automatic get_result(output int st, output int m, output int id, output int n);
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) chk("result_timeout", 32'(out_valid), 32'd1);
        st = int'(now_state);
        m  = int'(en_match);
        id = int'(match_id);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic send_sym(input int sym, output int st, output int m, output int id, output int lat);
        int guard = 0;
        int n;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) chk("ready_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        sym_in   = 4'(sym);
        @(posedge clk); #1;
        in_valid = 1'b0;
        get_result(st, m, id, n);
        lat = 1 + n;
    endtask

    int st, m, id, lat, n;
    int syms   [6] = '{6, 3, 1, 2, 4, 3};
    int exp_st [6] = '{0, 3, 4, 5, 8, 9};
    int exp_m  [6] = '{0, 0, 0, 1, 0, 1};
    int exp_id [6] = '{0, 0, 0, 1, 0, 4};
    int exp_lt [6] = '{2, 2, 2, 2, 3, 2};
    int g_cur  [9] = '{0, 1, 0, 3, 4, 1, 6, 2, 8};
    int g_sym  [9] = '{1, 2, 3, 1, 2, 5, 3, 4, 3};
    int g_nxt  [9] = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    int f_st   [4] = '{4, 5, 7, 9};
    int f_to   [4] = '{1, 2, 3, 3};
    int o_st   [4] = '{2, 5, 7, 9};
    int o_id   [4] = '{1, 1, 3, 4};
    logic seen_valid;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_state", 32'(now_state), 32'd0);
        chk("rst_en_match", 32'(en_match), 32'd0);
        chk("rst_match_id", 32'(match_id), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) cfg_write(2'd0, i, edge_e(g_cur[i], g_sym[i], g_nxt[i]));
        for (int i = 0; i < 4; i++) cfg_write(2'd1, f_st[i], c_dw'(f_to[i]));
        for (int i = 0; i < 4; i++) cfg_write(2'd2, o_st[i], c_dw'({1'b1, 4'(o_id[i])}));

        // Stream u,s,h,e,r,s
        for (int i = 0; i < 6; i++) begin
            send_sym(syms[i], st, m, id, lat);
            chk($sformatf("stream_state[%0d]", i), 32'(st), 32'(exp_st[i]));
            chk($sformatf("stream_match[%0d]", i), 32'(m), 32'(exp_m[i]));
            chk($sformatf("stream_id[%0d]", i), 32'(id), 32'(exp_id[i]));
            chk($sformatf("stream_lat[%0d]", i), 32'(lat), 32'(exp_lt[i]));
        end

        // Back-pressure: hold OUT_READY low with the next symbol already offered
        do_init();
        in_valid = 1'b1;
        sym_in   = 4'd1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b1;
        sym_in   = 4'd2;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("bp_hold_state", 32'(now_state), 32'd1);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        get_result(st, m, id, n);
        chk("bp_next_state", 32'(st), 32'd2);
        chk("bp_next_match", 32'(m), 32'd1);
        chk("bp_next_id", 32'(id), 32'd1);

        // Failure loop 3 <-> 4 with no matching edge
        do_init();
        cfg_write(2'd1, 3, c_dw'(4));
        cfg_write(2'd1, 4, c_dw'(3));
        send_sym(3, st, m, id, lat);
        chk("loop_setup_state", 32'(st), 32'd3);
        send_sym(6, st, m, id, lat);
        chk("loop_state", 32'(st), 32'd0);
        chk("loop_err", 32'(err), 32'd1);
        chk("loop_lat", 32'(lat), 32'(2 + NUM_STATES));
        do_init();
        chk("init_clears_err", 32'(err), 32'd0);

        // INITIALIZE in the middle of the long failure walk
        send_sym(3, st, m, id, lat);
        chk("abort_setup_state", 32'(st), 32'd3);
        in_valid = 1'b1;
        sym_in   = 4'd6;
        @(posedge clk); #1;
        in_valid   = 1'b0;
        seen_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            seen_valid |= out_valid;
        end
        do_init();
        repeat (40) begin
            seen_valid |= out_valid;
            @(posedge clk); #1;
        end
        chk("abort_no_valid", 32'(seen_valid), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_err", 32'(err), 32'd0);
        send_sym(1, st, m, id, lat);
        chk("abort_then_h", 32'(st), 32'd1);

        // Goto write while walking is dropped; the same write in IDLE is used
        in_valid = 1'b1;
        sym_in   = 4'd6;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cfg_write(2'd0, 9, edge_e(0, 6, 10));
        get_result(st, m, id, n);
        chk("cfg_busy_state", 32'(st), 32'd0);
        send_sym(6, st, m, id, lat);
        chk("cfg_dropped_state", 32'(st), 32'd0);
        cfg_write(2'd0, 9, edge_e(0, 6, 10));
        send_sym(6, st, m, id, lat);
        chk("cfg_idle_state", 32'(st), 32'd10);
        chk("cfg_idle_match", 32'(m), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
